// File: rtl/bcd_display_pkg.sv
// Shared types, segment codes and BCD-to-segment decode for the display counter.
package bcd_display_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 8;

    typedef logic [BCD_W-1:0] bcd_digit_t;
    typedef logic [SEG_W-1:0] seg_t;

    // Active-low segments, bit0=a .. bit6=g, bit7=dp (always off)
    localparam seg_t SEG_BLANK = 8'hFF;
    localparam seg_t SEG_CODES [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    function automatic seg_t bcd_to_seg(input bcd_digit_t d);
        return (d > 4'd9) ? SEG_BLANK : SEG_CODES[d];
    endfunction

endpackage

// File: rtl/bcd_display_counter_if.sv
// Control/load inputs and count/display outputs of the display counter.
interface bcd_display_counter_if
    import bcd_display_pkg::*;
#(
    parameter int unsigned NUM = 6
);
    logic                   enable;
    logic                   up_down;
    logic                   clear;
    logic                   load;
    bcd_digit_t [NUM-1:0]   load_value;
    bcd_digit_t [NUM-1:0]   count_value;
    logic                   wrap;
    seg_t       [NUM-1:0]   seven_segment;

    modport master (
        output enable, up_down, clear, load, load_value,
        input  count_value, wrap, seven_segment
    );

    modport slave (
        input  enable, up_down, clear, load, load_value,
        output count_value, wrap, seven_segment
    );
endinterface

// File: rtl/bcd_step.sv
// Combinational NUM-digit BCD increment/decrement with wrap flag.
module bcd_step
    import bcd_display_pkg::*;
#(
    parameter int unsigned NUM = 6
) (
    input  bcd_digit_t [NUM-1:0] i_value,
    input  logic                 i_up_down,
    output bcd_digit_t [NUM-1:0] o_next_c,
    output logic                 o_wrap_c
);

    logic w_carry;

    // Ripple carry (up) or borrow (down) from digit 0 upward
    always_comb begin
        o_next_c = i_value;
        w_carry  = 1'b1;
        for (int j = 0; j < int'(NUM); j++) begin
            if (w_carry) begin
                if (i_up_down) begin
                    if (i_value[j] >= 4'd9) begin
                        o_next_c[j] = 4'd0;
                    end else begin
                        o_next_c[j] = i_value[j] + 4'd1;
                        w_carry     = 1'b0;
                    end
                end else begin
                    if (i_value[j] == 4'd0) begin
                        o_next_c[j] = 4'd9;
                    end else begin
                        o_next_c[j] = i_value[j] - 4'd1;
                        w_carry     = 1'b0;
                    end
                end
            end
        end
        o_wrap_c = w_carry;
    end

endmodule

// File: rtl/bcd_display_counter.sv
// Up/down BCD counter with rate timer, load/clear, wrap pulse and
// leading-zero-blanked seven-segment outputs.
module bcd_display_counter
    import bcd_display_pkg::*;
#(
    parameter int unsigned NUM           = 6,
    parameter int unsigned CLOCK_HZ      = 50000000,
    parameter int unsigned COUNT_RATE_HZ = 10,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bcd_display_counter_if.slave  bus
);

    localparam int unsigned TIMEOUT = CLOCK_HZ / COUNT_RATE_HZ;
    localparam int unsigned TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TIMEOUT_M1 = TMR_W'(TIMEOUT - 1);

    bcd_digit_t [NUM-1:0] r_count;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_wrap;
    seg_t       [NUM-1:0] r_seg;

    bcd_digit_t [NUM-1:0] w_step_value;
    logic                 w_step_wrap;
    bcd_digit_t [NUM-1:0] w_count_nxt;
    logic [TMR_W-1:0]     w_timer_nxt;
    logic                 w_wrap_nxt;
    seg_t       [NUM-1:0] w_seg_nxt;
    logic                 w_zero_run;

    bcd_step #(.NUM(NUM)) u_step (
        .i_value   (r_count),
        .i_up_down (bus.up_down),
        .o_next_c  (w_step_value),
        .o_wrap_c  (w_step_wrap)
    );

    // Next count/timer/wrap: clear > load > step > hold
    always_comb begin
        w_count_nxt = r_count;
        w_timer_nxt = r_timer;
        w_wrap_nxt  = 1'b0;
        if (bus.clear) begin
            w_count_nxt = '0;
            w_timer_nxt = '0;
        end else if (bus.load) begin
            for (int j = 0; j < int'(NUM); j++) begin
                w_count_nxt[j] = (bus.load_value[j] > 4'd9) ? 4'd9 : bus.load_value[j];
            end
            w_timer_nxt = '0;
        end else if (bus.enable) begin
            if (r_timer == TIMEOUT_M1) begin
                w_timer_nxt = '0;
                w_count_nxt = w_step_value;
                w_wrap_nxt  = w_step_wrap;
            end else begin
                w_timer_nxt = r_timer + TMR_W'(1);
            end
        end
    end

    // Segment decode of the current count; a digit blanks when it and all above are zero
    always_comb begin
        w_seg_nxt  = '0;
        w_zero_run = 1'b1;
        for (int j = int'(NUM) - 1; j >= 0; j--) begin
            w_zero_run = w_zero_run && (r_count[j] == 4'd0);
            if (BLANK_LEADING && (j > 0) && w_zero_run) begin
                w_seg_nxt[j] = SEG_BLANK;
            end else begin
                w_seg_nxt[j] = bcd_to_seg(r_count[j]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= '0;
            r_timer <= '0;
            r_wrap  <= 1'b0;
            for (int j = 0; j < int'(NUM); j++) begin
                r_seg[j] <= (BLANK_LEADING && (j != 0)) ? SEG_BLANK : SEG_CODES[0];
            end
        end else begin
            r_count <= w_count_nxt;
            r_timer <= w_timer_nxt;
            r_wrap  <= w_wrap_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign bus.count_value   = r_count;
    assign bus.wrap          = r_wrap;
    assign bus.seven_segment = r_seg;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Scoreboard bench: two counter configurations driven with directed and random
// stimulus, checked against an integer reference model.
module tb_bcd_display_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn0, rn1;
    bcd_display_counter_if #(.NUM(2)) bus0();
    bcd_display_counter_if #(.NUM(4)) bus1();

    bcd_display_counter #(
        .NUM(2), .CLOCK_HZ(4), .COUNT_RATE_HZ(1), .BLANK_LEADING(1'b1)
    ) dut0 (.clock(clk), .reset_n(rn0), .bus(bus0));

    bcd_display_counter #(
        .NUM(4), .CLOCK_HZ(5), .COUNT_RATE_HZ(5), .BLANK_LEADING(1'b0)
    ) dut1 (.clock(clk), .reset_n(rn1), .bus(bus1));

    typedef struct {
        int          cyc;
        logic [23:0] cnt;
        logic        wrap;
        logic [47:0] seg;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    int NUMS [2] = '{2, 4};
    int TOS  [2] = '{4, 1};
    int BLK  [2] = '{1, 0};
    int m_cnt[2] = '{0, 0};
    int m_tmr[2] = '{0, 0};
    logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [23:0] to_bcd(input int v, input int n);
        logic [23:0] r = '0;
        for (int j = 0; j < n; j++) r[4*j +: 4] = 4'((v / pow10(j)) % 10);
        return r;
    endfunction

    function automatic logic [47:0] to_seg(input int d, input int v);
        logic [47:0] r = '0;
        for (int j = 0; j < NUMS[d]; j++) begin
            if (BLK[d] != 0 && j > 0 && v < pow10(j)) r[8*j +: 8] = 8'hFF;
            else r[8*j +: 8] = lut[(v / pow10(j)) % 10];
        end
        return r;
    endfunction

    // Drive one cycle of inputs and push the model's expectation for the next edge
    task automatic apply(input int d, input bit rn, input bit c, input bit l,
                         input bit e, input bit u, input logic [15:0] lv);
        exp_t x;
        int lvc, dig, old, md;
        bit w;
        @(posedge clk);
        #1;
        if (d == 0) begin
            rn0 = rn; bus0.clear = c; bus0.load = l; bus0.enable = e;
            bus0.up_down = u; bus0.load_value = lv[7:0];
        end else begin
            rn1 = rn; bus1.clear = c; bus1.load = l; bus1.enable = e;
            bus1.up_down = u; bus1.load_value = lv;
        end
        lvc = 0;
        for (int j = 0; j < NUMS[d]; j++) begin
            dig = int'(lv[4*j +: 4]);
            if (dig > 9) dig = 9;
            lvc += dig * pow10(j);
        end
        md  = pow10(NUMS[d]);
        old = m_cnt[d];
        w   = 1'b0;
        if (!rn || c) begin
            m_cnt[d] = 0; m_tmr[d] = 0;
        end else if (l) begin
            m_cnt[d] = lvc; m_tmr[d] = 0;
        end else if (e) begin
            if (m_tmr[d] == TOS[d] - 1) begin
                m_tmr[d] = 0;
                if (u) begin
                    if (m_cnt[d] == md - 1) begin m_cnt[d] = 0; w = 1'b1; end
                    else m_cnt[d] = m_cnt[d] + 1;
                end else begin
                    if (m_cnt[d] == 0) begin m_cnt[d] = md - 1; w = 1'b1; end
                    else m_cnt[d] = m_cnt[d] - 1;
                end
            end else begin
                m_tmr[d] = m_tmr[d] + 1;
            end
        end
        x.cyc  = cyc + 1;
        x.cnt  = to_bcd(m_cnt[d], NUMS[d]);
        x.wrap = w;
        x.seg  = rn ? to_seg(d, old) : to_seg(d, 0);
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic check(input string name, input int d, input logic [47:0] act,
                         input logic [47:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, req);
        end
    endtask

    // Monitor: compare every registered output against the queued expectation
    always @(negedge clk) begin
        exp_t x;
        while (q0.size() > 0 && q0[0].cyc <= cyc) begin
            x = q0.pop_front();
            check("count", 0, 48'(bus0.count_value), 48'(x.cnt));
            check("wrap", 0, 48'(bus0.wrap), 48'(x.wrap));
            check("seg", 0, 48'(bus0.seven_segment), x.seg);
        end
        while (q1.size() > 0 && q1[0].cyc <= cyc) begin
            x = q1.pop_front();
            check("count", 1, 48'(bus1.count_value), 48'(x.cnt));
            check("wrap", 1, 48'(bus1.wrap), 48'(x.wrap));
            check("seg", 1, 48'(bus1.seven_segment), x.seg);
        end
    end

    task automatic seq0();
        int r;
        logic [15:0] lv;
        repeat (2) apply(0, 0, 0, 0, 0, 1, 16'h0);
        repeat (46) apply(0, 1, 0, 0, 1, 1, 16'h0);
        apply(0, 1, 0, 1, 1, 1, 16'h0099);
        repeat (6) apply(0, 1, 0, 0, 1, 1, 16'h0);
        apply(0, 1, 0, 1, 1, 0, 16'h0000);
        repeat (6) apply(0, 1, 0, 0, 1, 0, 16'h0);
        apply(0, 1, 0, 1, 0, 1, 16'h00C3);
        apply(0, 1, 0, 0, 0, 1, 16'h0);
        apply(0, 1, 1, 1, 1, 1, 16'h0055);
        repeat (2) apply(0, 1, 0, 0, 1, 1, 16'h0);
        repeat (10) apply(0, 1, 0, 0, 0, 1, 16'h0);
        repeat (3) apply(0, 1, 0, 0, 1, 1, 16'h0);
        repeat (3) apply(0, 1, 0, 0, 1, 1, 16'h0);
        apply(0, 1, 1, 0, 1, 1, 16'h0);
        repeat (5) apply(0, 1, 0, 0, 1, 1, 16'h0);
        repeat (6) apply(0, 1, 0, 0, 1, 1, 16'h0);
        apply(0, 0, 0, 0, 1, 1, 16'h0);
        repeat (5) apply(0, 1, 0, 0, 1, 1, 16'h0);
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 99));
            lv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) lv = ($urandom_range(0, 1) == 0) ? 16'h0099 : 16'h0000;
            apply(0, r >= 2, r >= 2 && r < 5, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)), lv);
        end
    endtask

    task automatic seq1();
        int r;
        logic [15:0] lv;
        repeat (2) apply(1, 0, 0, 0, 0, 1, 16'h0);
        repeat (15) apply(1, 1, 0, 0, 1, 1, 16'h0);
        apply(1, 1, 0, 1, 1, 1, 16'h9998);
        repeat (3) apply(1, 1, 0, 0, 1, 1, 16'h0);
        apply(1, 1, 0, 1, 1, 0, 16'h0001);
        repeat (3) apply(1, 1, 0, 0, 1, 0, 16'h0);
        apply(1, 1, 0, 1, 0, 1, 16'hFA3C);
        repeat (4) apply(1, 1, 0, 0, 1, 1, 16'h0);
        apply(1, 0, 0, 0, 1, 1, 16'h0);
        repeat (3) apply(1, 1, 0, 0, 1, 1, 16'h0);
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 4))
                0: lv = 16'h9999;
                1: lv = 16'h0000;
                2: lv = 16'h9997;
                3: lv = 16'h0002;
                default: lv = 16'($urandom);
            endcase
            apply(1, r >= 2, r >= 2 && r < 5, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)), lv);
        end
    endtask

    initial begin
        rn0 = 1'b0; rn1 = 1'b0;
        bus0.clear = 1'b0; bus0.load = 1'b0; bus0.enable = 1'b0;
        bus0.up_down = 1'b1; bus0.load_value = '0;
        bus1.clear = 1'b0; bus1.load = 1'b0; bus1.enable = 1'b0;
        bus1.up_down = 1'b1; bus1.load_value = '0;
        fork
            seq0();
            seq1();
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (q0.size() + q1.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0", q0.size() + q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
